lsu: RTL and testbench



---
 rtl/proc_pkg.sv | 18 +
 rtl/lsu_align.sv | 64 ++++++
 rtl/lsu.sv | 123 ++++++++++++
 tb/tb_lsu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor-side types and constants.
// Holds the load/store unit state encoding and the RV32I load/store size codes.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper for the load/store unit: legality check, byte enables and
// write replication on the request side, lane extraction and extension on the load side.
module lsu_align
    import proc_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        illegal,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_ext
);

    logic [31:0] byte_shift;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        illegal   = 1'b0;
        case (funct3)
            LSU_F3_B, LSU_F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            LSU_F3_H, LSU_F3_HU: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                illegal   = addr_lo[0];
            end
            LSU_F3_W: begin
                be      = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned size codes only exist for loads.
        if (we && funct3[2]) begin
            illegal = 1'b1;
        end
    end

    assign byte_shift = rdata >> {ld_addr_lo, 3'b000};
    assign byte_lane  = byte_shift[7:0];
    assign half_lane  = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        rdata_ext = rdata;
        case (ld_funct3)
            LSU_F3_B:  rdata_ext = {{24{byte_lane[7]}}, byte_lane};
            LSU_F3_BU: rdata_ext = {24'h000000, byte_lane};
            LSU_F3_H:  rdata_ext = {{16{half_lane[15]}}, half_lane};
            LSU_F3_HU: rdata_ext = {16'h0000, half_lane};
            default:   rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: stalls the memory stage while one access runs over the
// request/grant + read-valid data memory port, then reports load data or an error.
module lsu
    import proc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        m_req_i,
    input  logic        m_we_i,
    input  logic [2:0]  m_funct3_i,
    input  logic [31:0] m_addr_i,
    input  logic [31:0] m_wdata_i,
    output logic        m_stall_o,
    output logic [31:0] m_rdata_o,
    output logic        m_rvalid_o,
    output logic        m_err_o,
    output logic        dm_req_o,
    input  logic        dm_gnt_i,
    output logic        dm_we_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_din_o,
    input  logic        dm_rvalid_i,
    input  logic [31:0] dm_dout_i
);

    lsu_state_t  state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_inc;
    logic        timeout_hit;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic        illegal;
    logic [31:0] rdata_ext;

    lsu_align u_align (
        .we         (m_we_i),
        .funct3     (m_funct3_i),
        .addr_lo    (m_addr_i[1:0]),
        .wdata      (m_wdata_i),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .illegal    (illegal),
        .ld_funct3  (f3_q),
        .ld_addr_lo (lo_q),
        .rdata      (dm_dout_i),
        .rdata_ext  (rdata_ext)
    );

    assign m_stall_o   = m_req_i & (state_q != RESP);
    assign cnt_inc     = cnt_q + 8'd1;
    // Abort on the edge where the counter would reach TIMEOUT-1.
    assign timeout_hit = (cnt_inc == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            f3_q       <= 3'd0;
            lo_q       <= 2'd0;
            dm_req_o   <= 1'b0;
            dm_we_o    <= 1'b0;
            dm_be_o    <= 4'd0;
            dm_addr_o  <= 32'd0;
            dm_din_o   <= 32'd0;
            m_rdata_o  <= 32'd0;
            m_rvalid_o <= 1'b0;
            m_err_o    <= 1'b0;
        end else begin
            m_rvalid_o <= 1'b0;
            m_err_o    <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (m_req_i) begin
                        if (illegal) begin
                            m_err_o <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            dm_req_o  <= 1'b1;
                            dm_we_o   <= m_we_i;
                            dm_addr_o <= {m_addr_i[31:2], 2'b00};
                            dm_be_o   <= be;
                            dm_din_o  <= wdata_rep;
                            f3_q      <= m_funct3_i;
                            lo_q      <= m_addr_i[1:0];
                            state_q   <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_inc;
                    if (dm_gnt_i) begin
                        dm_req_o <= 1'b0;
                        state_q  <= dm_we_o ? RESP : WAIT;
                    end else if (timeout_hit) begin
                        dm_req_o <= 1'b0;
                        m_err_o  <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_inc;
                    if (dm_rvalid_i) begin
                        m_rdata_o  <= rdata_ext;
                        m_rvalid_o <= 1'b1;
                        state_q    <= RESP;
                    end else if (timeout_hit) begin
                        m_err_o <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and random accesses against a small memory responder,
// with expectations from a size/offset arithmetic model of the load/store rules.
module tb_lsu;

    localparam int unsigned TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        m_req_i;
    logic        m_we_i;
    logic [2:0]  m_funct3_i;
    logic [31:0] m_addr_i;
    logic [31:0] m_wdata_i;
    logic        m_stall_o;
    logic [31:0] m_rdata_o;
    logic        m_rvalid_o;
    logic        m_err_o;
    logic        dm_req_o;
    logic        dm_gnt_i;
    logic        dm_we_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_din_o;
    logic        dm_rvalid_i;
    logic [31:0] dm_dout_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = 32'd0;

    lsu #(.TIMEOUT(TO)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .m_req_i     (m_req_i),
        .m_we_i      (m_we_i),
        .m_funct3_i  (m_funct3_i),
        .m_addr_i    (m_addr_i),
        .m_wdata_i   (m_wdata_i),
        .m_stall_o   (m_stall_o),
        .m_rdata_o   (m_rdata_o),
        .m_rvalid_o  (m_rvalid_o),
        .m_err_o     (m_err_o),
        .dm_req_o    (dm_req_o),
        .dm_gnt_i    (dm_gnt_i),
        .dm_we_o     (dm_we_o),
        .dm_be_o     (dm_be_o),
        .dm_addr_o   (dm_addr_o),
        .dm_din_o    (dm_din_o),
        .dm_rvalid_i (dm_rvalid_i),
        .dm_dout_i   (dm_dout_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic ok;
        if (we) ok = (f3 <= 3'd2);
        else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return ok && ((addr % size_of(f3)) == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int v;
        v = ((1 << size_of(f3)) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_din(input logic [2:0] f3, input logic [31:0] wdata);
        if (size_of(f3) == 1) return {24'd0, wdata[7:0]} * 32'h01010101;
        if (size_of(f3) == 2) return {16'd0, wdata[15:0]} * 32'h00010001;
        return wdata;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        int          nbits;
        logic [31:0] v;
        nbits = 8 * size_of(f3);
        v = word >> (8 * (addr % 4));
        if (nbits < 32) begin
            v = v & ((32'd1 << nbits) - 32'd1);
            if (!f3[2] && v >= (32'd1 << (nbits - 1))) v = v - (32'd1 << nbits);
        end
        return v;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; gnt_lat counts REQ cycles before grant, rv_lat cycles from grant to rvalid.
    task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] word,
                                  input int gnt_lat, input int rv_lat, input bit back2back);
        logic legal;
        int   total, exp_stall, exp_req, stall_cnt, req_cnt, since;
        logic exp_err, exp_rv, granted, done;
        legal = model_legal(we, f3, addr);
        if (legal) begin
            total   = gnt_lat + 1 + (we ? 0 : rv_lat);
            exp_err = (total > int'(TO) - 1);
            if (total > int'(TO) - 1) total = int'(TO) - 1;
            exp_stall = 1 + total;
            exp_req   = (gnt_lat + 1 < int'(TO) - 1) ? gnt_lat + 1 : int'(TO) - 1;
        end else begin
            exp_err   = 1'b1;
            exp_stall = 1;
            exp_req   = 0;
        end
        exp_rv    = legal && !we && !exp_err;
        stall_cnt = 0;
        req_cnt   = 0;
        since     = 0;
        granted   = 1'b0;
        done      = 1'b0;
        @(negedge clk_i);
        m_req_i     = 1'b1;
        m_we_i      = we;
        m_funct3_i  = f3;
        m_addr_i    = addr;
        m_wdata_i   = wdata;
        dm_gnt_i    = 1'b0;
        dm_rvalid_i = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (!m_stall_o) begin
                done = 1'b1;
            end else begin
                stall_cnt++;
                dm_gnt_i    = 1'b0;
                dm_rvalid_i = 1'b0;
                if (dm_req_o) begin
                    if (req_cnt == 0) begin
                        check_output("dm_we", {31'd0, dm_we_o}, {31'd0, we});
                        check_output("dm_addr", dm_addr_o, addr & 32'hFFFF_FFFC);
                        check_output("dm_be", {28'd0, dm_be_o}, {28'd0, model_be(f3, addr)});
                        if (we) check_output("dm_din", dm_din_o, model_din(f3, wdata));
                    end
                    if (req_cnt == gnt_lat) begin
                        dm_gnt_i = 1'b1;
                        granted  = 1'b1;
                    end
                    req_cnt++;
                end else if (granted) begin
                    since++;
                    if (since == rv_lat) begin
                        dm_rvalid_i = 1'b1;
                        dm_dout_i   = word;
                    end
                end
                @(negedge clk_i);
            end
        end
        dm_gnt_i    = 1'b0;
        dm_rvalid_i = 1'b0;
        check_output("resp_reached", {31'd0, done}, 32'd1);
        if (exp_rv) exp_rdata = model_load(f3, addr, word);
        check_output("stall_cycles", stall_cnt, exp_stall);
        check_output("req_cycles", req_cnt, exp_req);
        check_output("err_pulse", {31'd0, m_err_o}, {31'd0, exp_err});
        check_output("rvalid_pulse", {31'd0, m_rvalid_o}, {31'd0, exp_rv});
        check_output("rdata", m_rdata_o, exp_rdata);
        if (!back2back) begin
            @(negedge clk_i);
            m_req_i = 1'b0;
            #1;
            check_output("err_one_cycle", {31'd0, m_err_o}, 32'd0);
            check_output("rvalid_one_cycle", {31'd0, m_rvalid_o}, 32'd0);
        end
    endtask

    // Starts an LW and pulls reset while it is in REQ or, after a grant, in WAIT.
    task automatic reset_mid_access(input bit in_wait);
        @(negedge clk_i);
        m_req_i = 1'b1; m_we_i = 1'b0; m_funct3_i = 3'b010;
        m_addr_i = 32'h0000_3000; m_wdata_i = 32'd0;
        @(negedge clk_i);
        #1;
        check_output("rst_pre_req", {31'd0, dm_req_o}, 32'd1);
        if (in_wait) begin
            dm_gnt_i = 1'b1;
            @(negedge clk_i);
            dm_gnt_i = 1'b0;
            #1;
        end
        #1;
        rst_n_i = 1'b0;
        #1;
        exp_rdata = 32'd0;
        check_output("rst_dm_req", {31'd0, dm_req_o}, 32'd0);
        check_output("rst_dm_be", {28'd0, dm_be_o}, 32'd0);
        check_output("rst_dm_addr", dm_addr_o, 32'd0);
        check_output("rst_rdata", m_rdata_o, exp_rdata);
        m_req_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        logic        r_we, b2b;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        rst_n_i = 1'b0; m_req_i = 1'b0; m_we_i = 1'b0; m_funct3_i = 3'd0;
        m_addr_i = 32'd0; m_wdata_i = 32'd0; dm_gnt_i = 1'b0;
        dm_rvalid_i = 1'b0; dm_dout_i = 32'd0;
        #3;
        check_output("reset_dm_req", {31'd0, dm_req_o}, 32'd0);
        check_output("reset_dm_we", {31'd0, dm_we_o}, 32'd0);
        check_output("reset_dm_be", {28'd0, dm_be_o}, 32'd0);
        check_output("reset_dm_addr", dm_addr_o, 32'd0);
        check_output("reset_dm_din", dm_din_o, 32'd0);
        check_output("reset_rdata", m_rdata_o, 32'd0);
        check_output("reset_rvalid", {31'd0, m_rvalid_o}, 32'd0);
        check_output("reset_err", {31'd0, m_err_o}, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        $display("[TB] directed accesses");
        apply_stimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'd0, 0, 1, 1'b0);
        apply_stimulus(1'b0, 3'b000, 32'h0000_2002, 32'd0, 32'h1280_FF34, 0, 3, 1'b0);
        apply_stimulus(1'b0, 3'b100, 32'h0000_2002, 32'd0, 32'h1280_FF34, 0, 3, 1'b0);
        apply_stimulus(1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'h1280_FF34, 1, 1, 1'b0);
        apply_stimulus(1'b0, 3'b001, 32'h0000_2001, 32'd0, 32'h1280_FF34, 0, 1, 1'b0);
        apply_stimulus(1'b1, 3'b001, 32'h0000_2006, 32'h0000_BEEF, 32'd0, 2, 1, 1'b0);
        apply_stimulus(1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'h1111_2222, 100, 1, 1'b0);
        dm_rvalid_i = 1'b1;
        dm_dout_i   = 32'hDEAD_BEEF;
        @(negedge clk_i);
        dm_rvalid_i = 1'b0;
        #1;
        check_output("late_rvalid_ignored", m_rdata_o, exp_rdata);
        apply_stimulus(1'b0, 3'b011, 32'h0000_4000, 32'd0, 32'd0, 0, 1, 1'b0);
        apply_stimulus(1'b1, 3'b100, 32'h0000_4000, 32'd0, 32'd0, 0, 1, 1'b0);
        apply_stimulus(1'b1, 3'b010, 32'h0000_5000, 32'h0BAD_F00D, 32'd0, 0, 1, 1'b1);
        apply_stimulus(1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'h0BAD_F00D, 0, 1, 1'b0);
        apply_stimulus(1'b0, 3'b101, 32'h0000_6002, 32'd0, 32'h8001_7FFE, 2, 4, 1'b0);
        apply_stimulus(1'b0, 3'b000, 32'h0000_6001, 32'd0, 32'h8001_7FFE, 2, 5, 1'b0);
        apply_stimulus(1'b1, 3'b000, 32'h0000_6001, 32'h0000_0033, 32'd0, 6, 1, 1'b0);

        $display("[TB] reset during an access");
        reset_mid_access(1'b1);
        apply_stimulus(1'b0, 3'b010, 32'h0000_3004, 32'd0, 32'hCAFE_BABE, 1, 2, 1'b0);
        reset_mid_access(1'b0);
        apply_stimulus(1'b0, 3'b001, 32'h0000_3006, 32'd0, 32'hF00F_1234, 0, 1, 1'b0);

        $display("[TB] random accesses");
        for (int i = 0; i < 60; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            b2b    = 1'($urandom_range(0, 1));
            apply_stimulus(r_we, r_f3, r_addr, $urandom, $urandom,
                           int'($urandom_range(0, 4)), int'($urandom_range(1, 5)), b2b);
        end
        @(negedge clk_i);
        m_req_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
